// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/subtract with the carry chain cut into S
// registered segments, valid/ready handshake and global stall.
//
// Optional feature: define PIPE_ADDER_OVF_EN to add the oOvf port
// (signed overflow, registered and aligned with oS).
//
// Parameters:
//   N  operand/result width
//   S  pipeline stages (carry segments), N % S == 0, W = N/S
// Ports:
//   iClk, iRst_n       clock, async active-low reset
//   iA, iB, iC, iSub   operands, carry/borrow-in, subtract select
//   iValid / oReady    input handshake
//   oS, oC             result, carry-out (subtract: 1 = no borrow)
//   oValid / iReady    output handshake
//   oOvf               signed overflow (PIPE_ADDER_OVF_EN only)
module pipelined_adder #(
    parameter int N = 32,
    parameter int S = 4
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic [N-1:0] iA,
    input  logic [N-1:0] iB,
    input  logic         iC,
    input  logic         iSub,
    input  logic         iValid,
    output logic         oReady,
    output logic [N-1:0] oS,
    output logic         oC,
    output logic         oValid,
    input  logic         iReady
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic         oOvf
`endif
);

    localparam int W = N / S;

    logic         en;
    logic [N-1:0] b_cond;
    logic         c_cond;

    // Subtract is a + ~b + ~c, so both B and the carry-in are inverted.
    always_comb begin
        b_cond = iSub ? ~iB : iB;
        c_cond = iSub ? ~iC : iC;
    end

    // Stage k keeps the result bits produced so far (deskew) and the
    // operand segments not yet consumed (skew). Each stage strips its
    // own segment off the bottom before passing the rest along.
    for (genvar k = 0; k < S; k++) begin : g_stg
        localparam int RW = N - k * W;
        localparam int SW = (k + 1) * W;

        logic [RW-1:0] a_in;
        logic [RW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [W:0]    seg;
        logic [SW-1:0] s_d;
        logic [SW-1:0] s_q;
        logic          c_d;
        logic          c_q;
        logic          v_d;
        logic          v_q;

        if (k == 0) begin : g_head
            always_comb begin
                a_in = iA;
                b_in = b_cond;
                c_in = c_cond;
                v_in = iValid;
                s_d  = seg[W-1:0];
            end
        end else begin : g_tail
            always_comb begin
                a_in = g_stg[k-1].g_op.a_q;
                b_in = g_stg[k-1].g_op.b_q;
                c_in = g_stg[k-1].c_q;
                v_in = g_stg[k-1].v_q;
                s_d  = {seg[W-1:0], g_stg[k-1].s_q};
            end
        end

        always_comb begin
            seg = {1'b0, a_in[W-1:0]}
                + {1'b0, b_in[W-1:0]}
                + {{W{1'b0}}, c_in};
            c_d = seg[W];
            v_d = v_in;
        end

        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end

        if (k < S - 1) begin : g_op
            logic [RW-W-1:0] a_d;
            logic [RW-W-1:0] a_q;
            logic [RW-W-1:0] b_d;
            logic [RW-W-1:0] b_q;

            always_comb begin
                a_d = a_in[RW-1:W];
                b_d = b_in[RW-1:W];
            end

            always_ff @(posedge iClk or negedge iRst_n) begin
                if (!iRst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == S - 1) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is a ^ b ^ sum at that bit.
            always_comb begin
                ovf_d = a_in[W-1] ^ b_in[W-1] ^ seg[W-1] ^ seg[W];
            end

            always_ff @(posedge iClk or negedge iRst_n) begin
                if (!iRst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    assign oS     = g_stg[S-1].s_q;
    assign oC     = g_stg[S-1].c_q;
    assign oValid = g_stg[S-1].v_q;
`ifdef PIPE_ADDER_OVF_EN
    assign oOvf   = g_stg[S-1].g_ovf.ovf_q;
`endif

    // Global stall: the whole pipe moves only if the output slot frees.
    assign en     = ~oValid | iReady;
    assign oReady = en;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks for pipelined_adder
// (N=32/S=4 main instance, N=8/S=1 latency-1 instance).
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b, s;
    logic        cin, sub, vin, rdy_in;
    logic        rdy_out, cout, vout;
    logic [7:0]  a8, b8, s8;
    logic        c8, sub8, v8, r8;
    logic        rdy8, co8, vo8;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf, ovf8;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.N(32), .S(4)) u_dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iA     (a),
        .iB     (b),
        .iC     (cin),
        .iSub   (sub),
        .iValid (vin),
        .oReady (rdy_out),
        .oS     (s),
        .oC     (cout),
        .oValid (vout),
        .iReady (rdy_in)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .oOvf   (ovf)
`endif
    );

    pipelined_adder #(.N(8), .S(1)) u_dut8 (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iA     (a8),
        .iB     (b8),
        .iC     (c8),
        .iSub   (sub8),
        .iValid (v8),
        .oReady (rdy8),
        .oS     (s8),
        .oC     (co8),
        .oValid (vo8),
        .iReady (r8)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .oOvf   (ovf8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic isub,
                        input logic [31:0] es, input logic ec,
                        input string tag);
        int lat;
        a   = ia;
        b   = ib;
        cin = ic;
        sub = isub;
        vin = 1'b1;
        tick();
        vin = 1'b0;
        lat = 1;
        while (!vout && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, " lat"}, lat, 4);
        check({tag, " s"}, s, es);
        check({tag, " c"}, cout, ec);
    endtask

    logic [31:0] va [8] = '{32'h00000001, 32'h80000000, 32'h00000010,
                            32'h00000000, 32'h12345678, 32'hFFFF0000,
                            32'hDEADBEEF, 32'h00000000};
    logic [31:0] vb [8] = '{32'h00000002, 32'h80000000, 32'h00000001,
                            32'h00000001, 32'h11111111, 32'h0001FFFF,
                            32'h0000BEEF, 32'h00000000};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es [8] = '{32'h00000003, 32'h00000001, 32'h0000000F,
                            32'hFFFFFFFF, 32'h23456789, 32'h00010000,
                            32'hDEACFFFF, 32'hFFFFFFFF};
    logic        ec [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int in_idx;
        int out_idx;
        int cyc;

        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        sub    = 1'b0;
        vin    = 1'b0;
        rdy_in = 1'b1;
        a8     = '0;
        b8     = '0;
        c8     = 1'b0;
        sub8   = 1'b0;
        v8     = 1'b0;
        r8     = 1'b1;

        repeat (2) tick();
        check("rst valid", vout, 0);
        check("rst s", s, 0);
        check("rst c", cout, 0);
        check("rst ready", rdy_out, 1);
`ifdef PIPE_ADDER_OVF_EN
        check("rst ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("idle valid", vout, 0);
        end

        run1(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, "carry");
        run1(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, "sub1");
        run1(32'd7, 32'd5, 1'b1, 1'b1, 32'h00000001, 1'b1, "sub2");
        tick();
        check("drained", vout, 0);

        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        while (out_idx < 8 && cyc < 40) begin
            rdy_in = !(cyc >= 5 && cyc <= 7);
            if (!rdy_in)
                check("bp stall valid", vout, 1);
            if (vout) begin
                check("bp s", s, es[out_idx]);
                check("bp c", cout, ec[out_idx]);
                if (rdy_in)
                    out_idx++;
            end
            if (in_idx < 8) begin
                vin = 1'b1;
                a   = va[in_idx];
                b   = vb[in_idx];
                cin = vc[in_idx];
                sub = vs[in_idx];
            end else begin
                vin = 1'b0;
            end
            #1;
            check("bp ready", rdy_out, rdy_in);
            if (vin && rdy_out)
                in_idx++;
            tick();
            cyc++;
        end
        vin    = 1'b0;
        rdy_in = 1'b1;
        check("bp count", out_idx, 8);
        repeat (5) begin
            tick();
            check("bp no dup", vout, 0);
        end

        for (int i = 0; i < 3; i++) begin
            vin = 1'b1;
            a   = 32'd100 + 32'(i);
            b   = 32'd1;
            cin = 1'b0;
            sub = 1'b0;
            tick();
        end
        vin = 1'b0;
        tick();
        check("mid pre valid", vout, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid rst valid", vout, 0);
        check("mid rst s", s, 0);
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            check("mid gone", vout, 0);
        end

        a8 = 8'h7F;
        b8 = 8'h01;
        v8 = 1'b1;
        tick();
        v8 = 1'b0;
        check("s1 valid", vo8, 1);
        check("s1 s", s8, 8'h80);
        check("s1 c", co8, 0);
`ifdef PIPE_ADDER_OVF_EN
        check("s1 ovf", ovf8, 1);
`endif
        tick();
        check("s1 empty", vo8, 0);
        a8 = 8'hFF;
        b8 = 8'h01;
        v8 = 1'b1;
        tick();
        v8 = 1'b0;
        check("s1 wrap s", s8, 8'h00);
        check("s1 wrap c", co8, 1);

`ifdef PIPE_ADDER_OVF_EN
        run1(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, "ovf add");
        check("ovf add o", ovf, 1);
        run1(32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, "ovf sub");
        check("ovf sub o", ovf, 1);
        run1(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, "ovf none");
        check("ovf none o", ovf, 0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
